// File: rtl/cpu_alu_seq.sv
// rtl/cpu_alu_seq.sv - registered ALU with valid/ready handshake, Z/N/C/V/err flags
// Defining CPU_ALU_SEQ_MUL_EN makes op C a WIDTH-cycle shift-add multiply; otherwise op C is illegal.
module cpu_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             carry_flag,
  output logic             ovf_flag,
  output logic             err_flag
);
  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_INC  = 4'h8;
  localparam logic [3:0] OP_DEC  = 4'h9;
  localparam logic [3:0] OP_PASS = 4'hA;
  localparam logic [3:0] OP_SAR  = 4'hB;

`ifdef CPU_ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'hC;
  typedef enum logic {S_IDLE, S_MUL_RUN} state_t;
`else
  typedef enum logic {S_IDLE} state_t;
`endif

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, neg_q, neg_d, carry_q, carry_d;
  logic             ovf_q, ovf_d, err_q, err_d;

`ifdef CPU_ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] src_acc, src_mcand, step_acc;
  logic [WIDTH-1:0]   src_mplier;
`endif

  logic [SHAMT_W-1:0]    sh;
  logic                  is_sub;
  logic [WIDTH-1:0]      b_eff;
  logic [WIDTH:0]        sum_ext, shl_ext, shr_ext;
  logic signed [WIDTH:0] sar_ext;
  logic [WIDTH-1:0]      alu_res;
  logic                  alu_c, alu_v, alu_err;
  logic                  accept, start_mul;

  assign in_ready = reset & (state_q == S_IDLE) & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
`ifdef CPU_ALU_SEQ_MUL_EN
  assign start_mul = (op == OP_MUL);
`else
  assign start_mul = 1'b0;
`endif

  // One shared WIDTH+1 adder serves ADD/SUB/INC/DEC; bit WIDTH is carry or borrow.
  always_comb begin
    sh      = b[SHAMT_W-1:0];
    is_sub  = (op == OP_SUB) || (op == OP_DEC);
    b_eff   = ((op == OP_INC) || (op == OP_DEC)) ? WIDTH'(1) : b;
    sum_ext = is_sub ? ({1'b0, a} - {1'b0, b_eff}) : ({1'b0, a} + {1'b0, b_eff});
    shl_ext = {1'b0, a} << sh;
    shr_ext = {a, 1'b0} >> sh;
    sar_ext = $signed({a, 1'b0}) >>> sh;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (a[WIDTH-1] == (b_eff[WIDTH-1] ^ is_sub)) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      OP_PASS: alu_res = b;
      OP_SHL: begin
        alu_res = shl_ext[WIDTH-1:0];
        alu_c   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_ext[WIDTH:1];
        alu_c   = shr_ext[0];
      end
      OP_SAR: begin
        alu_res = sar_ext[WIDTH:1];
        alu_c   = sar_ext[0];
      end
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q & ~out_ready;
    result_d    = result_q;
    zero_d      = zero_q;
    neg_d       = neg_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    err_d       = err_q;
    if ((state_q == S_IDLE) && accept && !start_mul) begin
      result_d    = alu_res;
      zero_d      = ~alu_err & (alu_res == '0);
      neg_d       = alu_res[WIDTH-1];
      carry_d     = alu_c;
      ovf_d       = alu_v;
      err_d       = alu_err;
      out_valid_d = 1'b1;
    end
`ifdef CPU_ALU_SEQ_MUL_EN
    // Step 0 happens on the accept edge itself, so the last step lands WIDTH-1 edges later.
    src_acc    = (state_q == S_IDLE) ? '0 : acc_q;
    src_mcand  = (state_q == S_IDLE) ? {{WIDTH{1'b0}}, a} : mcand_q;
    src_mplier = (state_q == S_IDLE) ? b : mplier_q;
    step_acc   = src_acc + (src_mplier[0] ? src_mcand : '0);
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    cnt_d      = cnt_q;
    if ((state_q == S_IDLE) && accept && start_mul) begin
      state_d  = S_MUL_RUN;
      acc_d    = step_acc;
      mcand_d  = src_mcand << 1;
      mplier_d = src_mplier >> 1;
      cnt_d    = SHAMT_W'(1);
    end
    if (state_q == S_MUL_RUN) begin
      acc_d    = step_acc;
      mcand_d  = src_mcand << 1;
      mplier_d = src_mplier >> 1;
      cnt_d    = cnt_q + SHAMT_W'(1);
      if (cnt_q == SHAMT_W'(WIDTH-1)) begin
        state_d     = S_IDLE;
        result_d    = step_acc[WIDTH-1:0];
        zero_d      = (step_acc[WIDTH-1:0] == '0);
        neg_d       = step_acc[WIDTH-1];
        carry_d     = |step_acc[2*WIDTH-1:WIDTH];
        ovf_d       = 1'b0;
        err_d       = 1'b0;
        out_valid_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
`ifdef CPU_ALU_SEQ_MUL_EN
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
`ifdef CPU_ALU_SEQ_MUL_EN
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign zero_flag  = zero_q;
  assign neg_flag   = neg_q;
  assign carry_flag = carry_q;
  assign ovf_flag   = ovf_q;
  assign err_flag   = err_q;

endmodule

// File: tb/tb_cpu_alu_seq.sv
// tb/tb_cpu_alu_seq.sv - scoreboard bench for cpu_alu_seq with a behavioural arithmetic model
module tb_cpu_alu_seq;
  localparam int W     = 8;
  localparam int HALF  = 1 << (W - 1);
  localparam int FULLR = 1 << W;
`ifdef CPU_ALU_SEQ_MUL_EN
  localparam int MUL_LAT = W;
  localparam bit MUL_ON  = 1'b1;
`else
  localparam int MUL_LAT = 1;
  localparam bit MUL_ON  = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] r;
    logic z, n, c, v, e;
    int lat;
    int acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] a, b, result;
  logic [3:0]   op;
  logic         zf, nf, cf, vf, ef;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rnd_ready = 1'b0;
  bit   fixed_ready = 1'b1;
  bit   seen = 1'b0;
  exp_t sb_q[$];
  exp_t obs_x;

  cpu_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero_flag(zf), .neg_flag(nf), .carry_flag(cf),
    .ovf_flag(vf), .err_flag(ef)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] f_op, input logic [W-1:0] fa, input logic [W-1:0] fb);
    exp_t x;
    int ua, ub, sa, sb, s, full, sfull;
    bit arith;
    ua = int'(fa);
    ub = int'(fb);
    sa = (ua >= HALF) ? ua - FULLR : ua;
    sb = (ub >= HALF) ? ub - FULLR : ub;
    s = ub % W;
    full = 0; sfull = 0; arith = 0;
    x.r = '0; x.z = 0; x.n = 0; x.c = 0; x.v = 0; x.e = 0; x.lat = 1; x.acc = 0;
    case (f_op)
      4'h0: begin full = ua + ub; sfull = sa + sb; arith = 1; x.c = (full >= FULLR); end
      4'h1: begin full = ua - ub; sfull = sa - sb; arith = 1; x.c = (ua < ub); end
      4'h2: full = ua & ub;
      4'h3: full = ua | ub;
      4'h4: full = ua ^ ub;
      4'h5: full = FULLR - 1 - ua;
      4'h6: begin full = ua << s; x.c = (s != 0) && (((ua >> (W - s)) & 1) == 1); end
      4'h7: begin full = ua >> s; x.c = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
      4'h8: begin full = ua + 1; sfull = sa + 1; arith = 1; x.c = (full >= FULLR); end
      4'h9: begin full = ua - 1; sfull = sa - 1; arith = 1; x.c = (ua == 0); end
      4'hA: full = ub;
      4'hB: begin full = sa >>> s; x.c = (s != 0) && (((ua >> (s - 1)) & 1) == 1); end
      4'hC: begin
        if (MUL_ON) begin
          full = ua * ub;
          x.c = (full >= FULLR);
          x.lat = MUL_LAT;
        end else x.e = 1;
      end
      default: x.e = 1;
    endcase
    if (arith) x.v = (sfull >= HALF) || (sfull < -HALF);
    if (x.e) begin
      x.c = 0;
      x.v = 0;
    end else begin
      x.r = full[W-1:0];
      x.z = (x.r == 0);
      x.n = x.r[W-1];
    end
    return x;
  endfunction

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) seen = 1'b0;
    else if (out_valid) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: out_valid=1 result %0h with nothing outstanding at cycle %0d", result, cyc);
      end else if (cyc < sb_q[0].acc + sb_q[0].lat) begin
        checks++; errors++;
        $display("FAIL early_valid: out_valid=1 at cycle %0d, required from cycle %0d", cyc, sb_q[0].acc + sb_q[0].lat);
      end else begin
        chk("result", result, sb_q[0].r);
        chk("flags_zncve", {zf, nf, cf, vf, ef}, {sb_q[0].z, sb_q[0].n, sb_q[0].c, sb_q[0].v, sb_q[0].e});
        if (!seen) begin
          chk("latency", cyc - sb_q[0].acc, sb_q[0].lat);
          seen = 1'b1;
        end
        if (out_ready) begin
          void'(sb_q.pop_front());
          seen = 1'b0;
        end
      end
    end else if (sb_q.size() != 0 && cyc >= sb_q[0].acc + sb_q[0].lat) begin
      checks++; errors++;
      $display("FAIL missing_valid: out_valid=0 at cycle %0d, required from cycle %0d", cyc, sb_q[0].acc + sb_q[0].lat);
    end
  end

  // Accept observer: runs after the monitor so the queue reflects this cycle's drain.
  always begin
    @(negedge clk);
    #1;
    chk("in_ready", in_ready, reset && (sb_q.size() == 0));
    if (reset && in_valid && in_ready) begin
      obs_x = model(op, a, b);
      obs_x.acc = cyc;
      sb_q.push_back(obs_x);
    end
  end

  task automatic issue(input logic [3:0] t_op, input logic [W-1:0] ta, input logic [W-1:0] tb_);
    int waited;
    waited = 0;
    @(posedge clk);
    #1;
    op = t_op; a = ta; b = tb_; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      #2;
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        checks++; errors++;
        $display("FAIL accept_timeout: op %0h not accepted within 200 cycles", t_op);
        break;
      end
    end
  endtask

  task automatic drop();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = W'($urandom); b = W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("drain_outstanding", sb_q.size(), 0);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] t;
    case ($urandom_range(0, 5))
      0:       t = '0;
      1:       t = '1;
      2:       t = W'(HALF);
      3:       t = W'(HALF - 1);
      default: t = W'($urandom);
    endcase
    return t;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {zf, nf, cf, vf, ef}, 0);
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #3 reset = 1'b1;

    issue(4'h0, 8'hFF, 8'h01);
    issue(4'h1, 8'h80, 8'h01);
    issue(4'h1, 8'h00, 8'h01);
    issue(4'hC, 8'h0F, 8'h11);
    issue(4'hC, 8'h10, 8'h10);
    issue(4'h6, 8'h81, 8'h01);
    issue(4'h7, 8'h81, 8'h00);
    issue(4'hB, 8'h80, 8'h03);
    drop();
    drain();

    fixed_ready = 1'b0;
    issue(4'h0, 8'h01, 8'h02);
    fork
      begin
        repeat (6) @(posedge clk);
        fixed_ready = 1'b1;
      end
    join_none
    issue(4'h4, 8'h5A, 8'h0F);
    drop();
    drain();

    rnd_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      issue(4'($urandom_range(0, 15)), pick(), pick());
      if ($urandom_range(0, 3) == 0) begin
        drop();
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
    end
    drop();
    rnd_ready = 1'b0;
    fixed_ready = 1'b1;
    drain();

    fixed_ready = 1'b0;
    issue(4'hC, 8'h0F, 8'h11);
    drop();
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    sb_q.delete();
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_result", result, 0);
    chk("async_rst_flags", {zf, nf, cf, vf, ef}, 0);
    chk("async_rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    fixed_ready = 1'b1;
    repeat (12) @(posedge clk);
    issue(4'hE, 8'h33, 8'h44);
    drop();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
